// File: rtl/pipeline_hazard_unit_if.sv
// Hazard-unit boundary: pipeline stage register info in, stall/flush/forward controls out.
// Combinational control path plus two perf counters; the pipeline drives master, the unit is slave.
// No backpressure of its own: stalls are the backpressure this unit exerts on the pipeline.
interface pipeline_hazard_unit_if #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
);
    logic [RA_W-1:0]  id_rs1;
    logic [RA_W-1:0]  id_rs2;
    logic             id_use1;
    logic             id_use2;
    logic [RA_W-1:0]  ex_rs1;
    logic [RA_W-1:0]  ex_rs2;
    logic [RA_W-1:0]  ex_rd;
    logic             ex_wr_en;
    logic             ex_is_load;
    logic [RA_W-1:0]  mem_rd;
    logic             mem_wr_en;
    logic             mem_req;
    logic [RA_W-1:0]  wb_rd;
    logic             wb_wr_en;
    logic             branch_taken;
    logic             cnt_clr;

    logic             stall_if;
    logic             stall_id;
    logic             stall_ex;
    logic             stall_mem;
    logic             flush_id;
    logic             flush_ex;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             mem_busy;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_use1, id_use2, ex_rs1, ex_rs2, ex_rd, ex_wr_en,
               ex_is_load, mem_rd, mem_wr_en, mem_req, wb_rd, wb_wr_en, branch_taken, cnt_clr,
        input  stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, fwd_a, fwd_b,
               mem_busy, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use1, id_use2, ex_rs1, ex_rs2, ex_rd, ex_wr_en,
               ex_is_load, mem_rd, mem_wr_en, mem_req, wb_rd, wb_wr_en, branch_taken, cnt_clr,
        output stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, fwd_a, fwd_b,
               mem_busy, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Five-stage pipeline hazard unit: forwarding select, load-use stall, branch flush, memory-wait stall.
// Latency: all controls combinational in the same cycle; counters update on the next clk edge.
// Backpressure: a multi-cycle data access freezes every stage until the access completes.
module pipeline_hazard_unit #(
    parameter int XLEN    = 64,
    parameter int RA_W    = 5,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_unit_if.slave hz
);

    if (XLEN < 1 || MEM_LAT < 1 || MEM_LAT > 16) begin : g_bad_param
        $error("pipeline_hazard_unit: XLEN must be positive and MEM_LAT within 1..16");
    end

    localparam logic [RA_W-1:0]  REG_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [3:0]       WAIT_INIT = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;
    localparam bit               MULTI_CYCLE = (MEM_LAT > 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       wait_q;
    logic [3:0]       wait_d;
    logic             busy;
    logic             load_use;
    logic             stall_if;
    logic             stall_id;
    logic             stall_ex;
    logic             stall_mem;
    logic             flush_id;
    logic             flush_ex;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // The access that raises mem_busy in IDLE is its first busy cycle, so WAIT only covers MEM_LAT-2 more.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        busy    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hz.mem_req && MULTI_CYCLE) begin
                    busy    = 1'b1;
                    state_d = S_WAIT;
                    wait_d  = WAIT_INIT;
                end
            end
            S_WAIT: begin
                if (wait_q != 4'd0) begin
                    busy   = 1'b1;
                    wait_d = wait_q - 4'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                wait_d  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign load_use = hz.ex_is_load && hz.ex_wr_en && (hz.ex_rd != REG_ZERO) &&
                      ((hz.id_use1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_use2 && (hz.id_rs2 == hz.ex_rd)));

    // Memory wait outranks a redirect, and a redirect squashes the instruction that caused load-use.
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        fwd_a     = 2'b00;
        fwd_b     = 2'b00;
        if (rst) begin
            if (busy) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                stall_ex  = 1'b1;
                stall_mem = 1'b1;
            end else if (hz.branch_taken) begin
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end else if (load_use) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                flush_ex = 1'b1;
            end

            if (hz.mem_wr_en && (hz.mem_rd != REG_ZERO) && (hz.mem_rd == hz.ex_rs1)) begin
                fwd_a = 2'b01;
            end else if (hz.wb_wr_en && (hz.wb_rd != REG_ZERO) && (hz.wb_rd == hz.ex_rs1)) begin
                fwd_a = 2'b10;
            end

            if (hz.mem_wr_en && (hz.mem_rd != REG_ZERO) && (hz.mem_rd == hz.ex_rs2)) begin
                fwd_b = 2'b01;
            end else if (hz.wb_wr_en && (hz.wb_rd != REG_ZERO) && (hz.wb_rd == hz.ex_rs2)) begin
                fwd_b = 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (hz.cnt_clr) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_if && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_id && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign hz.stall_if  = stall_if;
    assign hz.stall_id  = stall_id;
    assign hz.stall_ex  = stall_ex;
    assign hz.stall_mem = stall_mem;
    assign hz.flush_id  = flush_id;
    assign hz.flush_ex  = flush_ex;
    assign hz.fwd_a     = fwd_a;
    assign hz.fwd_b     = fwd_b;
    assign hz.mem_busy  = rst && busy;
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench: three instances (MEM_LAT 4/3/1) share one stimulus stream, checked against hand-derived values.
module tb_pipeline_hazard_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pipeline_hazard_unit_if #(.RA_W(5), .CNT_W(4))  h4();
    pipeline_hazard_unit_if #(.RA_W(5), .CNT_W(4))  h3();
    pipeline_hazard_unit_if #(.RA_W(5), .CNT_W(32)) h1();

    pipeline_hazard_unit #(.XLEN(64), .RA_W(5), .MEM_LAT(4), .CNT_W(4))  u4 (.clk(clk), .rst(rst), .hz(h4));
    pipeline_hazard_unit #(.XLEN(64), .RA_W(5), .MEM_LAT(3), .CNT_W(4))  u3 (.clk(clk), .rst(rst), .hz(h3));
    pipeline_hazard_unit #(.XLEN(64), .RA_W(5), .MEM_LAT(1), .CNT_W(32)) u1 (.clk(clk), .rst(rst), .hz(h1));

    assign h3.id_rs1 = h4.id_rs1;       assign h1.id_rs1 = h4.id_rs1;
    assign h3.id_rs2 = h4.id_rs2;       assign h1.id_rs2 = h4.id_rs2;
    assign h3.id_use1 = h4.id_use1;     assign h1.id_use1 = h4.id_use1;
    assign h3.id_use2 = h4.id_use2;     assign h1.id_use2 = h4.id_use2;
    assign h3.ex_rs1 = h4.ex_rs1;       assign h1.ex_rs1 = h4.ex_rs1;
    assign h3.ex_rs2 = h4.ex_rs2;       assign h1.ex_rs2 = h4.ex_rs2;
    assign h3.ex_rd = h4.ex_rd;         assign h1.ex_rd = h4.ex_rd;
    assign h3.ex_wr_en = h4.ex_wr_en;   assign h1.ex_wr_en = h4.ex_wr_en;
    assign h3.ex_is_load = h4.ex_is_load; assign h1.ex_is_load = h4.ex_is_load;
    assign h3.mem_rd = h4.mem_rd;       assign h1.mem_rd = h4.mem_rd;
    assign h3.mem_wr_en = h4.mem_wr_en; assign h1.mem_wr_en = h4.mem_wr_en;
    assign h3.mem_req = h4.mem_req;     assign h1.mem_req = h4.mem_req;
    assign h3.wb_rd = h4.wb_rd;         assign h1.wb_rd = h4.wb_rd;
    assign h3.wb_wr_en = h4.wb_wr_en;   assign h1.wb_wr_en = h4.wb_wr_en;
    assign h3.branch_taken = h4.branch_taken; assign h1.branch_taken = h4.branch_taken;
    assign h3.cnt_clr = h4.cnt_clr;     assign h1.cnt_clr = h4.cnt_clr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        h4.id_rs1 = '0; h4.id_rs2 = '0; h4.id_use1 = 1'b0; h4.id_use2 = 1'b0;
        h4.ex_rs1 = '0; h4.ex_rs2 = '0; h4.ex_rd = '0; h4.ex_wr_en = 1'b0; h4.ex_is_load = 1'b0;
        h4.mem_rd = '0; h4.mem_wr_en = 1'b0; h4.mem_req = 1'b0;
        h4.wb_rd = '0; h4.wb_wr_en = 1'b0; h4.branch_taken = 1'b0; h4.cnt_clr = 1'b0;
    endtask

    task automatic set_load_use();
        h4.ex_rd = 5'd5; h4.ex_wr_en = 1'b1; h4.ex_is_load = 1'b1;
        h4.id_rs1 = 5'd5; h4.id_use1 = 1'b1;
    endtask

    task automatic settle_and_clear();
        clear_inputs();
        repeat (5) tick();
        h4.cnt_clr = 1'b1;
        tick();
        h4.cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        set_load_use();
        h4.branch_taken = 1'b1; h4.mem_req = 1'b1;
        h4.mem_rd = 5'd3; h4.mem_wr_en = 1'b1; h4.ex_rs1 = 5'd3; h4.ex_rs2 = 5'd3;
        #1;
        checks++; if (h4.fwd_a !== 2'b00) begin failures++; $display("FAIL rst_fwd_a got=%b exp=00", h4.fwd_a); end
        tick();
        checks++; if (h4.stall_cnt !== 4'd0) begin failures++; $display("FAIL rst_stall_cnt got=%0d exp=0", h4.stall_cnt); end
        checks++; if (h4.flush_cnt !== 4'd0) begin failures++; $display("FAIL rst_flush_cnt got=%0d exp=0", h4.flush_cnt); end
        checks++; if ({h4.stall_if, h4.stall_id, h4.stall_ex, h4.stall_mem} !== 4'b0000) begin failures++; $display("FAIL rst_stalls got=%b exp=0000", {h4.stall_if, h4.stall_id, h4.stall_ex, h4.stall_mem}); end
        checks++; if ({h4.flush_id, h4.flush_ex, h4.mem_busy} !== 3'b000) begin failures++; $display("FAIL rst_flush_busy got=%b exp=000", {h4.flush_id, h4.flush_ex, h4.mem_busy}); end
        checks++; if (h4.fwd_b !== 2'b00) begin failures++; $display("FAIL rst_fwd_b got=%b exp=00", h4.fwd_b); end
        clear_inputs();
        rst = 1'b1;
        tick();
        checks++; if (h4.mem_busy !== 1'b0) begin failures++; $display("FAIL rst_idle_busy got=%b exp=0", h4.mem_busy); end
    endtask

    task automatic test_load_use();
        settle_and_clear();
        set_load_use();
        #1;
        checks++; if ({h4.stall_if, h4.stall_id, h4.flush_ex} !== 3'b111) begin failures++; $display("FAIL lu_assert got=%b exp=111", {h4.stall_if, h4.stall_id, h4.flush_ex}); end
        checks++; if ({h4.stall_ex, h4.stall_mem, h4.flush_id} !== 3'b000) begin failures++; $display("FAIL lu_others got=%b exp=000", {h4.stall_ex, h4.stall_mem, h4.flush_id}); end
        tick();
        checks++; if (h4.stall_cnt !== 4'd1) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=1", h4.stall_cnt); end
        h4.id_use1 = 1'b0;
        #1;
        checks++; if (h4.stall_if !== 1'b0) begin failures++; $display("FAIL lu_unused_src got=%b exp=0", h4.stall_if); end
        h4.id_use1 = 1'b0; h4.id_use2 = 1'b1; h4.id_rs2 = 5'd5;
        #1;
        checks++; if (h4.flush_ex !== 1'b1) begin failures++; $display("FAIL lu_rs2 got=%b exp=1", h4.flush_ex); end
        h4.ex_rd = 5'd0; h4.id_rs2 = 5'd0;
        #1;
        checks++; if (h4.stall_id !== 1'b0) begin failures++; $display("FAIL lu_x0 got=%b exp=0", h4.stall_id); end
        clear_inputs();
        tick();
        checks++; if (h4.stall_cnt !== 4'd1) begin failures++; $display("FAIL lu_cnt_hold got=%0d exp=1", h4.stall_cnt); end
    endtask

    task automatic test_forwarding();
        clear_inputs();
        h4.mem_rd = 5'd3; h4.wb_rd = 5'd3; h4.mem_wr_en = 1'b1; h4.wb_wr_en = 1'b1;
        h4.ex_rs1 = 5'd3; h4.ex_rs2 = 5'd0;
        #1;
        checks++; if (h4.fwd_a !== 2'b01) begin failures++; $display("FAIL fwd_mem_prio got=%b exp=01", h4.fwd_a); end
        checks++; if (h4.fwd_b !== 2'b00) begin failures++; $display("FAIL fwd_b_x0 got=%b exp=00", h4.fwd_b); end
        h4.mem_rd = 5'd0;
        #1;
        checks++; if (h4.fwd_a !== 2'b10) begin failures++; $display("FAIL fwd_wb got=%b exp=10", h4.fwd_a); end
        h4.mem_rd = 5'd7; h4.ex_rs2 = 5'd7; h4.mem_wr_en = 1'b0;
        #1;
        checks++; if (h4.fwd_b !== 2'b00) begin failures++; $display("FAIL fwd_b_nowr got=%b exp=00", h4.fwd_b); end
        h4.mem_wr_en = 1'b1;
        #1;
        checks++; if ({h4.fwd_a, h4.fwd_b} !== 4'b1001) begin failures++; $display("FAIL fwd_split got=%b exp=1001", {h4.fwd_a, h4.fwd_b}); end
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        logic [3:0] exp4;
        logic [3:0] exp3;
        exp4 = 4'b0111;
        exp3 = 4'b1011;
        settle_and_clear();
        h4.mem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (h4.mem_busy !== exp4[i]) begin failures++; $display("FAIL mw4_busy c%0d got=%b exp=%b", i, h4.mem_busy, exp4[i]); end
            checks++; if (h4.stall_mem !== exp4[i]) begin failures++; $display("FAIL mw4_stall_mem c%0d got=%b exp=%b", i, h4.stall_mem, exp4[i]); end
            checks++; if (h3.mem_busy !== exp3[i]) begin failures++; $display("FAIL mw3_busy c%0d got=%b exp=%b", i, h3.mem_busy, exp3[i]); end
            checks++; if (h1.mem_busy !== 1'b0) begin failures++; $display("FAIL mw1_busy c%0d got=%b exp=0", i, h1.mem_busy); end
            tick();
        end
        checks++; if (h4.stall_cnt !== 4'd3) begin failures++; $display("FAIL mw4_stall_cnt got=%0d exp=3", h4.stall_cnt); end
        checks++; if (h1.stall_cnt !== 32'd0) begin failures++; $display("FAIL mw1_stall_cnt got=%0d exp=0", h1.stall_cnt); end
        #1;
        checks++; if (h4.mem_busy !== 1'b1) begin failures++; $display("FAIL mw4_back_to_back got=%b exp=1", h4.mem_busy); end
        clear_inputs();
    endtask

    task automatic test_branch_during_mem();
        logic [2:0] exp_flush;
        exp_flush = 3'b100;
        settle_and_clear();
        h4.mem_req = 1'b1; h4.branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({h3.flush_id, h3.flush_ex} !== {2{exp_flush[i]}}) begin failures++; $display("FAIL br3_flush c%0d got=%b%b exp=%b%b", i, h3.flush_id, h3.flush_ex, exp_flush[i], exp_flush[i]); end
            checks++; if (h4.flush_id !== 1'b0) begin failures++; $display("FAIL br4_flush c%0d got=%b exp=0", i, h4.flush_id); end
            tick();
        end
        clear_inputs();
        checks++; if (h3.flush_cnt !== 4'd1) begin failures++; $display("FAIL br3_flush_cnt got=%0d exp=1", h3.flush_cnt); end
        checks++; if (h3.stall_cnt !== 4'd2) begin failures++; $display("FAIL br3_stall_cnt got=%0d exp=2", h3.stall_cnt); end
        checks++; if (h4.flush_cnt !== 4'd0) begin failures++; $display("FAIL br4_flush_cnt got=%0d exp=0", h4.flush_cnt); end
    endtask

    task automatic test_branch_priority();
        settle_and_clear();
        set_load_use();
        h4.branch_taken = 1'b1;
        #1;
        checks++; if ({h4.flush_id, h4.flush_ex} !== 2'b11) begin failures++; $display("FAIL bp_flush got=%b exp=11", {h4.flush_id, h4.flush_ex}); end
        checks++; if ({h4.stall_if, h4.stall_id} !== 2'b00) begin failures++; $display("FAIL bp_stall got=%b exp=00", {h4.stall_if, h4.stall_id}); end
        tick();
        clear_inputs();
        checks++; if ({h4.flush_cnt, h4.stall_cnt} !== {4'd1, 4'd0}) begin failures++; $display("FAIL bp_cnts got=%0d/%0d exp=1/0", h4.flush_cnt, h4.stall_cnt); end
    endtask

    task automatic test_reset_mid_wait();
        settle_and_clear();
        h4.mem_req = 1'b1;
        #1;
        checks++; if (h4.mem_busy !== 1'b1) begin failures++; $display("FAIL rw_start got=%b exp=1", h4.mem_busy); end
        tick();
        h4.mem_req = 1'b0;
        #1;
        checks++; if (h4.mem_busy !== 1'b1) begin failures++; $display("FAIL rw_wait got=%b exp=1", h4.mem_busy); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if ({h4.mem_busy, h4.stall_if} !== 2'b00) begin failures++; $display("FAIL rw_in_rst got=%b exp=00", {h4.mem_busy, h4.stall_if}); end
        tick();
        rst = 1'b1;
        #1;
        checks++; if (h4.mem_busy !== 1'b0) begin failures++; $display("FAIL rw_after got=%b exp=0", h4.mem_busy); end
        checks++; if ({h4.stall_cnt, h4.flush_cnt} !== 8'h00) begin failures++; $display("FAIL rw_cnts got=%0d/%0d exp=0/0", h4.stall_cnt, h4.flush_cnt); end
        h4.mem_req = 1'b1;
        #1;
        checks++; if (h4.mem_busy !== 1'b1) begin failures++; $display("FAIL rw_idle_accept got=%b exp=1", h4.mem_busy); end
        tick();
        clear_inputs();
    endtask

    task automatic test_saturation();
        settle_and_clear();
        set_load_use();
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 14) begin
                checks++; if (h4.stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_reach got=%0d exp=15", h4.stall_cnt); end
            end
        end
        checks++; if (h4.stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d exp=15", h4.stall_cnt); end
        checks++; if (h1.stall_cnt !== 32'd16) begin failures++; $display("FAIL sat_wide got=%0d exp=16", h1.stall_cnt); end
        h4.cnt_clr = 1'b1;
        tick();
        checks++; if (h4.stall_cnt !== 4'd0) begin failures++; $display("FAIL sat_clr got=%0d exp=0", h4.stall_cnt); end
        checks++; if (h1.stall_cnt !== 32'd0) begin failures++; $display("FAIL sat_clr_wide got=%0d exp=0", h1.stall_cnt); end
        h4.cnt_clr = 1'b0;
        tick();
        checks++; if (h4.stall_cnt !== 4'd1) begin failures++; $display("FAIL sat_restart got=%0d exp=1", h4.stall_cnt); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forwarding();
        test_mem_wait();
        test_branch_during_mem();
        test_branch_priority();
        test_reset_mid_wait();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
